frame_launch_sequencer: RTL and testbench

- Hardware replacement for the bench-driven per-frame loop around the streaming multiprocessor.
- For each animation frame it:
  - clears the framebuffer through a memory write port,
  - injects the per-frame angle into a warp parameter register,
  - launches one warp at a fixed PC and mask,
  - waits for that warp to exit,
  - hands the finished frame to a capture/scanout consumer.
- It sits between the host start/status interface and the SM launch/memory/register-file ports.

---
 rtl/frame_launch_sequencer.sv | 149 ++++++++++++++
 tb/tb_frame_launch_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_launch_sequencer.sv
// Per-frame launch sequencer: clears the framebuffer, writes the frame angle into
// a warp parameter register, launches one warp, waits for its exit and reports the frame.
module frame_launch_sequencer #(
  parameter int          NUM_FRAMES     = 48,
  parameter logic [15:0] ANGLE_STEP     = 16'h0555,
  parameter logic [31:0] FB_BASE        = 32'h2000,
  parameter int          FB_WORDS       = 128,
  parameter logic [7:0]  PARAM_REG      = 8'd15,
  parameter logic [31:0] LAUNCH_PC      = 32'h0,
  parameter logic [31:0] LAUNCH_MASK    = 32'h1,
  parameter int          TIMEOUT_CYCLES = 5_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        timeout_err,
  output logic        mem_wr_valid,
  input  logic        mem_wr_ready,
  output logic [31:0] mem_wr_addr,
  output logic [31:0] mem_wr_data,
  output logic        param_we,
  output logic [7:0]  param_reg,
  output logic [31:0] param_data,
  output logic        launch_valid,
  input  logic        launch_ready,
  output logic [31:0] launch_pc,
  output logic [31:0] launch_mask,
  input  logic        warp_exit,
  output logic        frame_valid,
  input  logic        frame_ready,
  output logic [7:0]  frame_idx
);

  // state  | meaning
  // IDLE   | waiting for start
  // CLEAR  | zeroing FB_WORDS framebuffer words
  // PARAM  | one-cycle angle write into the warp parameter register
  // LAUNCH | offering the warp launch until accepted
  // RUN    | waiting for warp exit, bounded by the timeout down-counter
  // REPORT | offering the finished frame to the consumer
  // DONE   | one-cycle end-of-run pulse
  typedef enum logic [2:0] {
    IDLE, CLEAR, PARAM, LAUNCH, RUN, REPORT, DONE
  } state_t;

  localparam int WC_W = (FB_WORDS > 1) ? $clog2(FB_WORDS) : 1;
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_t          state, next_state;
  logic [WC_W-1:0] word_cnt;
  logic [TO_W-1:0] to_cnt;
  logic [15:0]     angle;
  logic            last_word;
  logic            last_frame;
  logic            to_tc;

  assign last_word  = (word_cnt == WC_W'(FB_WORDS - 1));
  assign last_frame = (frame_idx == 8'(NUM_FRAMES - 1));
  assign to_tc      = (to_cnt == '0);

  always_comb begin
    next_state   = state;
    mem_wr_valid = 1'b0;
    param_we     = 1'b0;
    launch_valid = 1'b0;
    frame_valid  = 1'b0;
    done         = 1'b0;
    case (state)
      IDLE:   if (start) next_state = CLEAR;
      CLEAR: begin
        mem_wr_valid = 1'b1;
        if (mem_wr_ready && last_word) next_state = PARAM;
      end
      PARAM: begin
        param_we   = 1'b1;
        next_state = LAUNCH;
      end
      LAUNCH: begin
        launch_valid = 1'b1;
        if (launch_ready) next_state = RUN;
      end
      // exit takes priority over a coincident terminal count
      RUN:    if (warp_exit || to_tc) next_state = REPORT;
      REPORT: begin
        frame_valid = 1'b1;
        if (frame_ready) next_state = last_frame ? DONE : CLEAR;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      word_cnt    <= '0;
      to_cnt      <= '0;
      angle       <= '0;
      frame_idx   <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (start) begin
            word_cnt    <= '0;
            angle       <= '0;
            frame_idx   <= '0;
            timeout_err <= 1'b0;
          end
        end
        CLEAR: begin
          if (mem_wr_ready) word_cnt <= last_word ? '0 : word_cnt + 1'b1;
        end
        LAUNCH: begin
          if (launch_ready) to_cnt <= TO_W'(TIMEOUT_CYCLES - 1);
        end
        RUN: begin
          if (!warp_exit) begin
            if (to_tc) timeout_err <= 1'b1;
            else       to_cnt      <= to_cnt - 1'b1;
          end
        end
        REPORT: begin
          if (frame_ready && !last_frame) begin
            frame_idx <= frame_idx + 8'd1;
            angle     <= angle + ANGLE_STEP;
            word_cnt  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state != IDLE);
  assign mem_wr_addr = mem_wr_valid ? (FB_BASE + (32'(word_cnt) << 2)) : 32'h0;
  assign mem_wr_data = 32'h0;
  assign param_reg   = PARAM_REG;
  assign param_data  = param_we ? {16'h0, angle} : 32'h0;
  assign launch_pc   = LAUNCH_PC;
  assign launch_mask = LAUNCH_MASK;

endmodule

// File: tb/tb_frame_launch_sequencer.sv
// Directed bench for frame_launch_sequencer: a short-run/short-timeout instance for the
// handshake, stall, timeout and reset cases, plus a full-length instance for the angle sweep.
module tb_frame_launch_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start;
  logic        busy, done, timeout_err;
  logic        mem_wr_valid, mem_wr_ready;
  logic [31:0] mem_wr_addr, mem_wr_data;
  logic        param_we;
  logic [7:0]  param_reg;
  logic [31:0] param_data;
  logic        launch_valid, launch_ready;
  logic [31:0] launch_pc, launch_mask;
  logic        warp_exit, frame_valid, frame_ready;
  logic [7:0]  frame_idx;

  frame_launch_sequencer #(.NUM_FRAMES(3), .TIMEOUT_CYCLES(20)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .timeout_err(timeout_err), .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .param_we(param_we),
    .param_reg(param_reg), .param_data(param_data), .launch_valid(launch_valid),
    .launch_ready(launch_ready), .launch_pc(launch_pc), .launch_mask(launch_mask),
    .warp_exit(warp_exit), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .frame_idx(frame_idx)
  );

  logic        start48, busy48, done48, timeout_err48;
  logic        mem_wr_valid48, param_we48, launch_valid48, frame_valid48, frame_ready48;
  logic [31:0] mem_wr_addr48, mem_wr_data48, param_data48, launch_pc48, launch_mask48;
  logic [7:0]  param_reg48, frame_idx48;
  logic        one = 1'b1;

  // SM side tied ready with warp_exit constantly high: every RUN cycle sees an exit
  frame_launch_sequencer dut48 (
    .clk(clk), .rst(rst), .start(start48), .busy(busy48), .done(done48),
    .timeout_err(timeout_err48), .mem_wr_valid(mem_wr_valid48), .mem_wr_ready(one),
    .mem_wr_addr(mem_wr_addr48), .mem_wr_data(mem_wr_data48), .param_we(param_we48),
    .param_reg(param_reg48), .param_data(param_data48), .launch_valid(launch_valid48),
    .launch_ready(one), .launch_pc(launch_pc48), .launch_mask(launch_mask48),
    .warp_exit(one), .frame_valid(frame_valid48), .frame_ready(frame_ready48),
    .frame_idx(frame_idx48)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state();
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_timeout_err", 32'(timeout_err), 32'h0);
    chk("rst_mem_wr_valid", 32'(mem_wr_valid), 32'h0);
    chk("rst_mem_wr_addr", mem_wr_addr, 32'h0);
    chk("rst_mem_wr_data", mem_wr_data, 32'h0);
    chk("rst_param_we", 32'(param_we), 32'h0);
    chk("rst_param_reg", 32'(param_reg), 32'd15);
    chk("rst_param_data", param_data, 32'h0);
    chk("rst_launch_valid", 32'(launch_valid), 32'h0);
    chk("rst_launch_pc", launch_pc, 32'h0);
    chk("rst_launch_mask", launch_mask, 32'h1);
    chk("rst_frame_valid", 32'(frame_valid), 32'h0);
    chk("rst_frame_idx", 32'(frame_idx), 32'h0);
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'h1);
    chk("start_timeout_err_cleared", 32'(timeout_err), 32'h0);
    chk("start_in_clear", 32'(mem_wr_valid), 32'h1);
  endtask

  // Entered with the DUT in CLEAR. w < 0 means the warp never exits.
  task automatic do_frame(input int idx, input bit last, input bit rand_rdy, input int w,
                          input bit exp_to, input int hold, input int lstall,
                          input int abort_at, input bit pulse_start, output bit aborted);
    int word;
    int cyc;
    logic [15:0] exp_angle;
    aborted   = 1'b0;
    exp_angle = 16'(idx * 32'h0555);
    word      = 0;
    for (int g = 0; g < 4000 && word < 128; g++) begin
      if (word == abort_at) begin
        rst   = 1'b1;
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        aborted = 1'b1;
        return;
      end
      start        = pulse_start && (word == 50);
      mem_wr_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      chk("clr_valid", 32'(mem_wr_valid), 32'h1);
      chk("clr_addr", mem_wr_addr, 32'(32'h2000 + 4 * word));
      chk("clr_data", mem_wr_data, 32'h0);
      if (mem_wr_ready) word++;
      tick();
    end
    start        = 1'b0;
    mem_wr_ready = 1'b0;
    chk("clr_words", 32'(word), 32'd128);
    chk("param_we", 32'(param_we), 32'h1);
    chk("param_data", param_data, {16'h0, exp_angle});
    chk("param_reg", 32'(param_reg), 32'd15);
    chk("param_frame_idx", 32'(frame_idx), 32'(idx));
    chk("param_no_write", 32'(mem_wr_valid), 32'h0);
    tick();
    chk("launch_param_we_drop", 32'(param_we), 32'h0);
    chk("launch_valid", 32'(launch_valid), 32'h1);
    chk("launch_pc", launch_pc, 32'h0);
    chk("launch_mask", launch_mask, 32'h1);
    for (int s = 0; s < lstall; s++) begin
      launch_ready = 1'b0;
      tick();
      chk("launch_hold", 32'(launch_valid), 32'h1);
    end
    launch_ready = 1'b1;
    tick();
    launch_ready = 1'b0;
    chk("run_launch_drop", 32'(launch_valid), 32'h0);
    cyc = 0;
    while (frame_valid !== 1'b1 && cyc < 100) begin
      warp_exit = (w >= 0) && (cyc >= w);
      chk("run_no_timeout_yet", 32'(timeout_err), 32'h0);
      tick();
      cyc++;
    end
    chk("run_cycles", 32'(cyc), (w >= 0) ? 32'(w + 1) : 32'd20);
    chk("rep_valid", 32'(frame_valid), 32'h1);
    chk("rep_idx", 32'(frame_idx), 32'(idx));
    chk("rep_timeout_err", 32'(timeout_err), 32'(exp_to));
    for (int h = 0; h < hold; h++) begin
      frame_ready = 1'b0;
      tick();
      chk("rep_hold_valid", 32'(frame_valid), 32'h1);
      chk("rep_hold_idx", 32'(frame_idx), 32'(idx));
    end
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    if (last) begin
      chk("done_pulse", 32'(done), 32'h1);
      chk("done_busy", 32'(busy), 32'h1);
      tick();
      chk("done_drop", 32'(done), 32'h0);
      chk("idle_busy", 32'(busy), 32'h0);
    end else begin
      chk("next_clear", 32'(mem_wr_valid), 32'h1);
      chk("next_no_done", 32'(done), 32'h0);
    end
  endtask

  initial begin
    bit ab;
    int pcount, hold, f_exp;
    bit seen_done;
    logic [15:0] a_exp;
    rst = 1'b1; start = 1'b0; mem_wr_ready = 1'b0; launch_ready = 1'b0;
    warp_exit = 1'b0; frame_ready = 1'b0; start48 = 1'b0; frame_ready48 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_reset_state();

    // run A: ready high, exit 10 cycles in, a stray start mid-CLEAR of frame 1
    start_run();
    do_frame(0, 0, 0, 10, 0, 0, 0, -1, 0, ab);
    do_frame(1, 0, 0, 10, 0, 0, 1, -1, 1, ab);
    do_frame(2, 1, 0, 10, 0, 0, 0, -1, 0, ab);

    // run B: random write stalls, stale exit, exit on the terminal cycle, timeout
    start_run();
    do_frame(0, 0, 1, 5, 0, 0, 2, -1, 0, ab);
    do_frame(1, 0, 1, 19, 0, 0, 0, -1, 0, ab);
    do_frame(2, 1, 1, -1, 1, 7, 0, -1, 0, ab);
    chk("timeout_err_sticky", 32'(timeout_err), 32'h1);
    tick();
    chk("timeout_err_sticky_idle", 32'(timeout_err), 32'h1);

    // run C: reset with a coincident start at word 40 of frame 1
    start_run();
    do_frame(0, 0, 0, 3, 0, 0, 0, -1, 0, ab);
    do_frame(1, 0, 0, 3, 0, 0, 0, 40, 0, ab);
    chk("aborted", 32'(ab), 32'h1);
    check_reset_state();
    tick();
    chk("rst_idle_stays", 32'(busy), 32'h0);

    // run D: fresh run after the abort starts at word 0, frame 0, angle 0
    start_run();
    do_frame(0, 0, 0, 2, 0, 1, 0, -1, 0, ab);
    do_frame(1, 0, 0, 2, 0, 0, 0, -1, 0, ab);
    do_frame(2, 1, 0, 2, 0, 0, 0, -1, 0, ab);

    // full-length instance: angle per frame and consumer back-pressure on the last frame
    start48 = 1'b1;
    tick();
    start48 = 1'b0;
    pcount = 0; hold = 0; f_exp = 0; seen_done = 1'b0; a_exp = 16'h0;
    for (int c = 0; c < 8000 && !seen_done; c++) begin
      frame_ready48 = 1'b1;
      if (param_we48) begin
        a_exp = 16'(pcount * 32'h0555);
        chk("angle48", param_data48, {16'h0, a_exp});
        pcount++;
      end
      if (frame_valid48) begin
        chk("idx48", 32'(frame_idx48), 32'(f_exp));
        if (frame_idx48 == 8'd47 && hold < 7) begin
          frame_ready48 = 1'b0;
          hold++;
        end else begin
          f_exp++;
        end
      end
      if (done48) seen_done = 1'b1;
      else tick();
    end
    frame_ready48 = 1'b0;
    chk("frames48", 32'(f_exp), 32'd48);
    chk("params48", 32'(pcount), 32'd48);
    chk("angle47", {16'h0, a_exp}, {16'h0, 16'(32'd47 * 32'h0555)});
    chk("hold48", 32'(hold), 32'd7);
    chk("done48", 32'(seen_done), 32'h1);
    chk("timeout_err48", 32'(timeout_err48), 32'h0);
    tick();
    chk("idle48", 32'(busy48), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
